// File: rtl/bp_me_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 slave among masters_p masters.
// A grant is held for the whole cyc, and a watchdog ends a stalled beat with err.
module bp_me_wb_arbiter #(
  parameter int masters_p    = 2,
  parameter int adr_width_p  = 37,
  parameter int data_width_p = 64,
  parameter int timeout_p    = 1024,
  localparam int sel_w       = data_width_p / 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [masters_p*adr_width_p-1:0]  m_adr_i,
  input  logic [masters_p*data_width_p-1:0] m_dat_i,
  input  logic [masters_p-1:0]              m_cyc_i,
  input  logic [masters_p-1:0]              m_stb_i,
  input  logic [masters_p*sel_w-1:0]        m_sel_i,
  input  logic [masters_p-1:0]              m_we_i,
  input  logic [masters_p*3-1:0]            m_cti_i,
  input  logic [masters_p*2-1:0]            m_bte_i,
  output logic [data_width_p-1:0]           m_dat_o,
  output logic [masters_p-1:0]              m_ack_o,
  output logic [masters_p-1:0]              m_err_o,
  output logic [masters_p-1:0]              m_gnt_o,
  output logic [adr_width_p-1:0]            s_adr_o,
  output logic [data_width_p-1:0]           s_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic [sel_w-1:0]                  s_sel_o,
  output logic                              s_we_o,
  output logic [2:0]                        s_cti_o,
  output logic [1:0]                        s_bte_o,
  input  logic [data_width_p-1:0]           s_dat_i,
  input  logic                              s_ack_i
);

  localparam int idx_w = $clog2(masters_p);
  localparam int cnt_w = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [cnt_w-1:0] timeout_lp = cnt_w'(timeout_p);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state;
  logic [masters_p-1:0] grant;
  logic [idx_w-1:0] gidx;
  logic [idx_w-1:0] ptr;
  logic [idx_w-1:0] winner;
  logic [idx_w-1:0] winner_next;
  logic             found;
  logic [cnt_w-1:0] cnt;
  logic             busy;
  logic             g_cyc;
  logic             g_stb;
  logic             wd_fire;

  assign busy    = (state == BUSY);
  assign g_cyc   = m_cyc_i[gidx];
  assign g_stb   = m_stb_i[gidx];
  assign wd_fire = (timeout_p > 0) && busy && g_stb && !s_ack_i && (cnt == timeout_lp);

  // First requester at or after ptr, wrapping around the master list.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < masters_p; i++) begin
      if (!found && m_cyc_i[(int'(ptr) + i) % masters_p]) begin
        winner = idx_w'((int'(ptr) + i) % masters_p);
        found  = 1'b1;
      end
    end
    winner_next = (winner == idx_w'(masters_p - 1)) ? '0 : winner + idx_w'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= BUSY;
            grant <= masters_p'(1) << winner;
            gidx  <= winner;
            ptr   <= winner_next;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall counter only advances while the owner holds cyc and stb without ack.
  always_ff @(posedge clk_i) begin
    if (reset_i || !busy || (timeout_p == 0)) begin
      cnt <= '0;
    end else if (g_cyc && g_stb && !s_ack_i) begin
      cnt <= wd_fire ? '0 : cnt + cnt_w'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_comb begin
    s_adr_o = m_adr_i[int'(gidx)*adr_width_p +: adr_width_p];
    s_dat_o = m_dat_i[int'(gidx)*data_width_p +: data_width_p];
    s_cti_o = m_cti_i[int'(gidx)*3 +: 3];
    s_bte_o = m_bte_i[int'(gidx)*2 +: 2];
    s_sel_o = busy ? m_sel_i[int'(gidx)*sel_w +: sel_w] : '0;
    s_we_o  = busy && m_we_i[gidx];
    s_cyc_o = busy && g_cyc;
    s_stb_o = busy && g_stb && !wd_fire;
    m_dat_o = s_dat_i;
    m_gnt_o = grant;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      m_ack_o[gidx] = s_ack_i && g_cyc && g_stb;
      m_err_o[gidx] = wd_fire;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(m_gnt_o));
      assert (((m_ack_o | m_err_o) & ~m_gnt_o) == '0);
      assert ((m_ack_o & m_err_o) == '0);
    end
  end

endmodule
